// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/flush/$0-suppression/T_new decrement; PIPE_STAGE_PERF_EN adds stall_cnt/bubble_cnt
module pipe_stage_reg #(
  parameter int N_DATA   = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SEL_W    = 2,
  parameter int TNEW_W   = 2,
  parameter int DEC_TNEW = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [N_DATA*DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic [ADDR_W-1:0]        in_waddr,
  input  logic                     in_regwrite,
  input  logic [SEL_W-1:0]         in_wsel,
  input  logic [TNEW_W-1:0]        in_tnew,
  output logic                     out_valid,
  output logic [N_DATA*DATA_W-1:0] out_data,
  output logic [DATA_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_waddr,
  output logic                     out_regwrite,
  output logic [SEL_W-1:0]         out_wsel,
  output logic [TNEW_W-1:0]        out_tnew
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              bubble_cnt
`endif
);
  logic                     load, bubble;
  logic                     nxt_valid, nxt_regwrite;
  logic [N_DATA*DATA_W-1:0] nxt_data;
  logic [ADDR_W-1:0]        nxt_waddr;
  logic [SEL_W-1:0]         nxt_wsel;
  logic [TNEW_W-1:0]        tnew_dec, nxt_tnew;
  // next-state values; a bubble zeroes everything except the PC
  always_comb begin
    load         = flush | en;
    bubble       = flush | ~in_valid;
    tnew_dec     = (DEC_TNEW != 0) ? ((in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1)) : in_tnew;
    nxt_valid    = ~bubble;
    nxt_data     = bubble ? '0 : in_data;
    nxt_waddr    = bubble ? '0 : in_waddr;
    nxt_wsel     = bubble ? '0 : in_wsel;
    nxt_tnew     = bubble ? '0 : tnew_dec;
    nxt_regwrite = ~bubble & in_regwrite & (in_waddr != '0);
  end
  // stage register: reset clears, flush/load update, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_pc       <= '0;
      out_waddr    <= '0;
      out_regwrite <= 1'b0;
      out_wsel     <= '0;
      out_tnew     <= '0;
    end else if (load) begin
      out_valid    <= nxt_valid;
      out_data     <= nxt_data;
      out_pc       <= in_pc;
      out_waddr    <= nxt_waddr;
      out_regwrite <= nxt_regwrite;
      out_wsel     <= nxt_wsel;
      out_tnew     <= nxt_tnew;
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  // saturating stall and bubble counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (!load && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (load && bubble && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg, DEC_TNEW=1 and DEC_TNEW=0 instances side by side
module tb_pipe_stage_reg;
  logic        clk = 0, reset = 0, en = 0, flush = 0, in_valid = 0, in_regwrite = 0;
  logic [63:0] in_data = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_waddr = '0;
  logic [1:0]  in_wsel = '0, in_tnew = '0;
  logic        v0, v1, rw0, rw1;
  logic [63:0] d0, d1;
  logic [31:0] p0, p1;
  logic [4:0]  a0, a1;
  logic [1:0]  s0, s1, t0, t1;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] sc0, bc0, sc1, bc1;
`endif
  typedef struct {
    logic        valid, regwrite;
    logic [63:0] data;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [1:0]  wsel, tnew_dec, tnew_raw;
    int          stalls, bubbles;
  } exp_t;
  exp_t m, q[$];
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEC_TNEW(1)) u0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_pc(in_pc), .in_waddr(in_waddr), .in_regwrite(in_regwrite), .in_wsel(in_wsel), .in_tnew(in_tnew),
    .out_valid(v0), .out_data(d0), .out_pc(p0), .out_waddr(a0), .out_regwrite(rw0), .out_wsel(s0), .out_tnew(t0)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc0), .bubble_cnt(bc0)
`endif
  );
  pipe_stage_reg #(.DEC_TNEW(0)) u1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_pc(in_pc), .in_waddr(in_waddr), .in_regwrite(in_regwrite), .in_wsel(in_wsel), .in_tnew(in_tnew),
    .out_valid(v1), .out_data(d1), .out_pc(p1), .out_waddr(a1), .out_regwrite(rw1), .out_wsel(s1), .out_tnew(t1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(sc1), .bubble_cnt(bc1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("valid", 64'(v0), 64'(e.valid));
    check("data", d0, e.data);
    check("pc", 64'(p0), 64'(e.pc));
    check("waddr", 64'(a0), 64'(e.waddr));
    check("regwrite", 64'(rw0), 64'(e.regwrite));
    check("wsel", 64'(s0), 64'(e.wsel));
    check("tnew_dec", 64'(t0), 64'(e.tnew_dec));
    check("tnew_raw", 64'(t1), 64'(e.tnew_raw));
    check("valid_nodec", 64'(v1), 64'(e.valid));
    check("regwrite_nodec", 64'(rw1), 64'(e.regwrite));
    check("pc_nodec", 64'(p1), 64'(e.pc));
    check("data_nodec", d1, e.data);
    check("waddr_nodec", 64'(a1), 64'(e.waddr));
    check("wsel_nodec", 64'(s1), 64'(e.wsel));
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 64'(sc0), 64'(e.stalls));
    check("bubble_cnt", 64'(bc0), 64'(e.bubbles));
    check("stall_cnt_nodec", 64'(sc1), 64'(e.stalls));
    check("bubble_cnt_nodec", 64'(bc1), 64'(e.bubbles));
`endif
  endtask

  task automatic model_clear();
    m.valid = 0; m.regwrite = 0; m.data = '0; m.pc = '0; m.waddr = '0;
    m.wsel = '0; m.tnew_dec = '0; m.tnew_raw = '0; m.stalls = 0; m.bubbles = 0;
  endtask

  task automatic step(input logic e_, f_, v_, input logic [63:0] d_, input logic [31:0] pc_,
                      input logic [4:0] wa_, input logic rw_, input logic [1:0] ws_, tn_);
    exp_t got;
    @(negedge clk);
    en = e_; flush = f_; in_valid = v_; in_data = d_; in_pc = pc_;
    in_waddr = wa_; in_regwrite = rw_; in_wsel = ws_; in_tnew = tn_;
    if (f_ || (e_ && !v_)) begin
      m.valid = 0; m.regwrite = 0; m.data = '0; m.pc = pc_; m.waddr = '0;
      m.wsel = '0; m.tnew_dec = '0; m.tnew_raw = '0;
      if (m.bubbles < 16'hFFFF) m.bubbles++;
    end else if (!e_) begin
      if (m.stalls < 16'hFFFF) m.stalls++;
    end else begin
      m.valid = 1; m.data = d_; m.pc = pc_; m.waddr = wa_; m.wsel = ws_;
      m.regwrite = rw_ && (wa_ != 0);
      m.tnew_dec = (tn_ == 0) ? 2'd0 : tn_ - 2'd1;
      m.tnew_raw = tn_;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      got = q.pop_front();
      check_all(got);
    end
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all(m);
    @(negedge clk);
    reset = 1;
    step(1, 0, 1, 64'h1111_2222_3333_4444, 32'h3000, 5'd8, 1, 2'd1, 2'd2);
    step(1, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 32'h3004, 5'd9, 1, 2'd2, 2'd0);
    step(1, 0, 1, 64'h5, 32'h3008, 5'd0, 1, 2'd3, 2'd3);
    step(1, 0, 1, 64'h6, 32'h300C, 5'd31, 1, 2'd3, 2'd1);
    step(0, 0, 1, 64'h7, 32'h4000, 5'd1, 0, 2'd0, 2'd2);
    step(0, 0, 0, 64'h8, 32'h4004, 5'd2, 1, 2'd1, 2'd0);
    step(0, 0, 1, 64'h9, 32'h4008, 5'd3, 1, 2'd2, 2'd3);
    step(0, 1, 1, 64'hF, 32'h3004, 5'd4, 1, 2'd1, 2'd3);
    step(1, 0, 0, 64'hE, 32'h5000, 5'd5, 1, 2'd1, 2'd3);
    step(1, 0, 1, 64'hDEAD_BEEF, 32'h6000, 5'd7, 1, 2'd2, 2'd3);
    @(negedge clk);
    en = 0;
    reset = 0;
    model_clear();
    #1;
    check_all(m);
    @(posedge clk);
    #1;
    check_all(m);
    @(negedge clk);
    reset = 1;
    step(0, 0, 1, 64'h1, 32'h7000, 5'd6, 1, 2'd1, 2'd2);
    step(1, 0, 1, 64'h2, 32'h7004, 5'd6, 1, 2'd1, 2'd2);
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) != 0,
           {$urandom, $urandom}, $urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           1'($urandom), 2'($urandom), 2'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
